// File: rtl/temp_monitor_mc_pkg.sv
// Shared types and default thresholds for the multi-channel temperature supervisor.
package temp_mon_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_ALARM  = 2'd1,
    ST_TRIP   = 2'd2
  } chan_state_e;

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_MIN_TEMP      = 99;
  localparam int DEF_ALARM_TEMP    = 200;
  localparam int DEF_SHUTDOWN_TEMP = 249;
  localparam int DEF_HYST          = 4;
  localparam int DEF_DEBOUNCE      = 3;

  // Channel index width; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/temp_monitor_mc_if.sv
// ADC sample input and supervisor status bundle between sequencer, monitor and power controller.
interface temp_monitor_mc_if
  import temp_mon_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH
) ();
  localparam int CH_W = ch_w(NUM_CH);

  logic                     adc_valid;
  logic [CH_W-1:0]          adc_ch;
  logic [DATA_W-1:0]        adc_data;
  logic                     clr_shutdown;
  logic [NUM_CH*DATA_W-1:0] temp_out;
  logic [NUM_CH-1:0]        temp_upd;
  logic [NUM_CH-1:0]        alarm;
  logic                     shutdown;
  logic [CH_W-1:0]          shutdown_src;
  logic [NUM_CH-1:0]        fault;
  logic                     ch_err;

  modport master (
    output adc_valid, adc_ch, adc_data, clr_shutdown,
    input  temp_out, temp_upd, alarm, shutdown, shutdown_src, fault, ch_err
  );

  modport slave (
    input  adc_valid, adc_ch, adc_data, clr_shutdown,
    output temp_out, temp_upd, alarm, shutdown, shutdown_src, fault, ch_err
  );
endinterface

// File: rtl/temp_monitor_mc_chan_fsm.sv
// One channel of the supervisor: debounce counters, NORMAL/ALARM/TRIP state, sticky fault,
// and a flag telling the top whether this channel's latest counted sample blocks a release.
module temp_chan_fsm
  import temp_mon_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MIN_TEMP      = DEF_MIN_TEMP,
  parameter int ALARM_TEMP    = DEF_ALARM_TEMP,
  parameter int SHUTDOWN_TEMP = DEF_SHUTDOWN_TEMP,
  parameter int HYST          = DEF_HYST,
  parameter int DEBOUNCE      = DEF_DEBOUNCE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              smp_vld_i,
  input  logic [DATA_W-1:0] smp_i,
  input  logic              release_i,
  output logic              alarm_o,
  output logic              fault_o,
  output logic              trip_enter_o,
  output logic              hot_o
);
  localparam int CNT_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0]  DEB_V   = CNT_W'(DEBOUNCE);
  localparam logic [DATA_W-1:0] MIN_V   = DATA_W'(MIN_TEMP);
  localparam logic [DATA_W-1:0] ALARM_V = DATA_W'(ALARM_TEMP);
  localparam logic [DATA_W-1:0] REL_V   = DATA_W'(ALARM_TEMP - HYST);
  localparam logic [DATA_W-1:0] SHUT_V  = DATA_W'(SHUTDOWN_TEMP);
  localparam logic [DATA_W-1:0] HOT_V   = DATA_W'(SHUTDOWN_TEMP - HYST);

  chan_state_e      state_q, state_s, state_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_s, a_cnt_d;
  logic [CNT_W-1:0] s_cnt_q, s_cnt_s, s_cnt_d;
  logic             fault_q, fault_d;
  logic             hot_q, hot_d;
  logic             trip_enter;
  logic             rel_trip;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= DEB_V) ? c : c + CNT_W'(1);
  endfunction

  // Sample-driven next state; fault samples leave counters and state untouched.
  always_comb begin
    state_s    = state_q;
    a_cnt_s    = a_cnt_q;
    s_cnt_s    = s_cnt_q;
    fault_d    = fault_q;
    hot_d      = hot_q;
    trip_enter = 1'b0;
    if (smp_vld_i) begin
      if (smp_i <= MIN_V) begin
        fault_d = 1'b1;
      end else begin
        hot_d   = (smp_i >= HOT_V);
        a_cnt_s = (smp_i > ALARM_V) ? sat_inc(a_cnt_q) : '0;
        s_cnt_s = (smp_i >= SHUT_V) ? sat_inc(s_cnt_q) : '0;
        case (state_q)
          ST_NORMAL: begin
            if (s_cnt_s == DEB_V)      state_s = ST_TRIP;
            else if (a_cnt_s == DEB_V) state_s = ST_ALARM;
          end
          ST_ALARM: begin
            if (s_cnt_s == DEB_V)      state_s = ST_TRIP;
            else if (smp_i <= REL_V)   state_s = ST_NORMAL;
          end
          default: ;
        endcase
        trip_enter = (state_q != ST_TRIP) && (state_s == ST_TRIP);
      end
    end
  end

  // The global release is computed from trip_enter/hot, so it is applied in a separate stage.
  assign rel_trip = release_i && (state_q == ST_TRIP);
  assign state_d  = rel_trip ? ST_NORMAL : state_s;
  assign a_cnt_d  = rel_trip ? '0 : a_cnt_s;
  assign s_cnt_d  = rel_trip ? '0 : s_cnt_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NORMAL;
      a_cnt_q <= '0;
      s_cnt_q <= '0;
      fault_q <= 1'b0;
      hot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_cnt_q <= a_cnt_d;
      s_cnt_q <= s_cnt_d;
      fault_q <= fault_d;
      hot_q   <= hot_d;
    end
  end

  assign alarm_o      = (state_q == ST_ALARM);
  assign fault_o      = fault_q;
  assign trip_enter_o = trip_enter;
  assign hot_o        = hot_d;

endmodule

// File: rtl/temp_monitor_mc.sv
// Multi-channel temperature supervisor: channel decode, filtered temperature storage,
// latched global shutdown with first-source capture and guarded release.
module temp_monitor_mc
  import temp_mon_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int MIN_TEMP      = DEF_MIN_TEMP,
  parameter int ALARM_TEMP    = DEF_ALARM_TEMP,
  parameter int SHUTDOWN_TEMP = DEF_SHUTDOWN_TEMP,
  parameter int HYST          = DEF_HYST,
  parameter int DEBOUNCE      = DEF_DEBOUNCE
) (
  input logic               clk,
  input logic               rst,
  temp_monitor_mc_if.slave  bus
);
  localparam int CH_W = ch_w(NUM_CH);
  localparam logic [DATA_W-1:0] MIN_V  = DATA_W'(MIN_TEMP);
  localparam logic [DATA_W-1:0] SHUT_V = DATA_W'(SHUTDOWN_TEMP);

  logic                     ch_ok;
  logic                     in_range;
  logic                     release_all;
  logic [NUM_CH-1:0]        sel, trip_enter, hot, alarm_v, fault_v;
  logic [NUM_CH*DATA_W-1:0] temp_q, temp_d;
  logic [NUM_CH-1:0]        upd_q, upd_d;
  logic                     shut_q, shut_d;
  logic [CH_W-1:0]          src_q, src_d, first_ch;
  logic                     ch_err_q, ch_err_d;

  assign ch_ok    = (32'(bus.adc_ch) < NUM_CH);
  assign in_range = (bus.adc_data > MIN_V) && (bus.adc_data < SHUT_V);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign sel[k] = bus.adc_valid && ch_ok && (bus.adc_ch == CH_W'(k));

    temp_chan_fsm #(
      .DATA_W(DATA_W), .MIN_TEMP(MIN_TEMP), .ALARM_TEMP(ALARM_TEMP),
      .SHUTDOWN_TEMP(SHUTDOWN_TEMP), .HYST(HYST), .DEBOUNCE(DEBOUNCE)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .smp_vld_i    (sel[k]),
      .smp_i        (bus.adc_data),
      .release_i    (release_all),
      .alarm_o      (alarm_v[k]),
      .fault_o      (fault_v[k]),
      .trip_enter_o (trip_enter[k]),
      .hot_o        (hot[k])
    );
  end

  always_comb begin
    first_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (trip_enter[k]) first_ch = CH_W'(k);
    end
  end

  // A tripping sample in the same cycle always beats a release request.
  assign release_all = shut_q && bus.clr_shutdown && !(|trip_enter) && !(|hot);

  always_comb begin
    temp_d   = temp_q;
    upd_d    = '0;
    shut_d   = shut_q;
    src_d    = src_q;
    ch_err_d = bus.adc_valid && !ch_ok;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel[k] && in_range) begin
        temp_d[k*DATA_W +: DATA_W] = bus.adc_data;
        upd_d[k]                   = 1'b1;
      end
    end
    if (|trip_enter) begin
      shut_d = 1'b1;
      if (!shut_q) src_d = first_ch;
    end else if (release_all) begin
      shut_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      temp_q   <= '0;
      upd_q    <= '0;
      shut_q   <= 1'b0;
      src_q    <= '0;
      ch_err_q <= 1'b0;
    end else begin
      temp_q   <= temp_d;
      upd_q    <= upd_d;
      shut_q   <= shut_d;
      src_q    <= src_d;
      ch_err_q <= ch_err_d;
    end
  end

  assign bus.temp_out     = temp_q;
  assign bus.temp_upd     = upd_q;
  assign bus.alarm        = alarm_v;
  assign bus.fault        = fault_v;
  assign bus.shutdown     = shut_q;
  assign bus.shutdown_src = src_q;
  assign bus.ch_err       = ch_err_q;

endmodule

// File: tb/tb_temp_monitor_mc.sv
// Bench for temp_monitor_mc: directed scenarios plus randomized traffic against a
// history-based reference model of the alarm/shutdown rules.
module tb_temp_monitor_mc;
  localparam int NCH = 4;
  localparam int MINT = 99, ALM = 200, SHT = 249, HYS = 4, DEB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  temp_monitor_mc_if #(.DATA_W(8), .NUM_CH(NCH)) bus ();
  temp_monitor_mc_if #(.DATA_W(8), .NUM_CH(5))   bus5 ();

  temp_monitor_mc #(.DATA_W(8), .NUM_CH(NCH)) dut  (.clk(clk), .rst(rst), .bus(bus));
  temp_monitor_mc #(.DATA_W(8), .NUM_CH(5))   dut5 (.clk(clk), .rst(rst), .bus(bus5));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: sample history per channel, alarm/trip flags, latched shutdown.
  bit          m_alarm[NCH];
  bit          m_trip[NCH];
  bit          m_fault[NCH];
  int          m_last[NCH];
  int          m_temp[NCH];
  int          hist[NCH][$];
  bit [NCH-1:0] m_upd;
  bit          m_shut;
  int          m_src;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_alarm[c] = 0; m_trip[c] = 0; m_fault[c] = 0;
      m_last[c] = 0; m_temp[c] = 0; hist[c].delete();
    end
    m_upd = '0; m_shut = 0; m_src = 0;
  endfunction

  // True when the newest DEB counted samples of channel c all satisfy the threshold.
  function automatic bit run_of(input int c, input int thr, input bit ge);
    if (hist[c].size() < DEB) return 0;
    for (int i = hist[c].size() - DEB; i < hist[c].size(); i++)
      if (ge ? (hist[c][i] < thr) : (hist[c][i] <= thr)) return 0;
    return 1;
  endfunction

  function automatic void model_step(input bit v, input int ch, input int d, input bit clr);
    bit tripped = 0;
    bit ok;
    m_upd = '0;
    if (v) begin
      if (d <= MINT) begin
        m_fault[ch] = 1;
      end else begin
        if (d < SHT) begin m_temp[ch] = d; m_upd[ch] = 1; end
        m_last[ch] = d;
        hist[ch].push_back(d);
        if (hist[ch].size() > DEB) void'(hist[ch].pop_front());
        if (!m_trip[ch] && run_of(ch, SHT, 1)) begin
          m_trip[ch] = 1; m_alarm[ch] = 0; tripped = 1;
          if (!m_shut) m_src = ch;
          m_shut = 1;
        end else if (!m_trip[ch]) begin
          if (m_alarm[ch] && d <= ALM - HYS) m_alarm[ch] = 0;
          else if (!m_alarm[ch] && run_of(ch, ALM, 0)) m_alarm[ch] = 1;
        end
      end
    end
    if (clr && m_shut && !tripped) begin
      ok = 1;
      for (int c = 0; c < NCH; c++) if (m_last[c] >= SHT - HYS) ok = 0;
      if (ok) begin
        m_shut = 0;
        for (int c = 0; c < NCH; c++)
          if (m_trip[c]) begin m_trip[c] = 0; hist[c].delete(); end
      end
    end
  endfunction

  task automatic step(input bit v, input int ch, input int d, input bit clr);
    bus.adc_valid = v; bus.adc_ch = 2'(ch); bus.adc_data = 8'(d); bus.clr_shutdown = clr;
    @(posedge clk);
    model_step(v, ch, d, clr);
    #1;
    bus.adc_valid = 1'b0; bus.clr_shutdown = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.adc_valid = 1'b1; bus.adc_ch = 2'd1; bus.adc_data = 8'd150; bus.clr_shutdown = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; bus.adc_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset_dut();
    step(1, 1, 150, 0);
    rst = 1'b1;
    bus.adc_valid = 1'b1; bus.adc_ch = 2'd1; bus.adc_data = 8'd150;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.temp_out, bus.temp_upd, bus.alarm, bus.fault, bus.shutdown, bus.shutdown_src, bus.ch_err} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs cyc %0d: temp=%h upd=%b alarm=%b fault=%b shut=%b src=%0d err=%b, want all 0",
                 i, bus.temp_out, bus.temp_upd, bus.alarm, bus.fault, bus.shutdown, bus.shutdown_src, bus.ch_err);
      end
    end
    rst = 1'b0; bus.adc_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_store();
    reset_dut();
    step(1, 1, 150, 0);
    n_cmp++; if (bus.temp_out[15:8] !== 8'd150) begin n_err++; $display("FAIL store_temp: got %0d want 150", bus.temp_out[15:8]); end
    n_cmp++; if (bus.temp_upd !== 4'b0010) begin n_err++; $display("FAIL store_upd: got %b want 0010", bus.temp_upd); end
    n_cmp++; if (bus.alarm !== 4'b0000) begin n_err++; $display("FAIL store_alarm: got %b want 0000", bus.alarm); end
    step(0, 0, 0, 0);
    n_cmp++; if (bus.temp_upd !== 4'b0000) begin n_err++; $display("FAIL store_upd_pulse: got %b want 0000", bus.temp_upd); end
    step(1, 1, 100, 0);
    n_cmp++; if (bus.temp_out[15:8] !== 8'd100 || bus.temp_upd !== 4'b0010) begin n_err++; $display("FAIL store_min_edge: got %0d/%b want 100/0010", bus.temp_out[15:8], bus.temp_upd); end
    step(1, 1, 248, 0);
    n_cmp++; if (bus.temp_out[15:8] !== 8'd248) begin n_err++; $display("FAIL store_max_edge: got %0d want 248", bus.temp_out[15:8]); end
  endtask

  task automatic test_alarm();
    int seq[6] = '{210, 210, 150, 210, 210, 210};
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      step(1, 2, seq[i], 0);
      n_cmp++;
      if (bus.alarm[2] !== (i == 5)) begin n_err++; $display("FAIL alarm_debounce sample %0d: got %b want %b", i, bus.alarm[2], (i == 5)); end
    end
    step(1, 2, 198, 0);
    n_cmp++; if (bus.alarm[2] !== 1'b1) begin n_err++; $display("FAIL alarm_hyst_hold: got %b want 1", bus.alarm[2]); end
    step(1, 2, 196, 0);
    n_cmp++; if (bus.alarm[2] !== 1'b0) begin n_err++; $display("FAIL alarm_release: got %b want 0", bus.alarm[2]); end
  endtask

  task automatic test_shutdown();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 249, 0);
      n_cmp++;
      if (bus.shutdown !== (i == 2)) begin n_err++; $display("FAIL shut_debounce sample %0d: got %b want %b", i, bus.shutdown, (i == 2)); end
    end
    n_cmp++; if (bus.shutdown_src !== 2'd0) begin n_err++; $display("FAIL shut_src: got %0d want 0", bus.shutdown_src); end
    n_cmp++; if (bus.temp_out[7:0] !== 8'd0 || bus.temp_upd !== 4'b0) begin n_err++; $display("FAIL shut_no_store: got %0d/%b want 0/0000", bus.temp_out[7:0], bus.temp_upd); end
    n_cmp++; if (bus.alarm !== 4'b0) begin n_err++; $display("FAIL shut_alarm: got %b want 0000", bus.alarm); end
    step(0, 0, 0, 1);
    n_cmp++; if (bus.shutdown !== 1'b1) begin n_err++; $display("FAIL shut_clr_ignored: got %b want 1", bus.shutdown); end
    step(1, 0, 120, 0);
    n_cmp++; if (bus.shutdown !== 1'b1 || bus.temp_out[7:0] !== 8'd120) begin n_err++; $display("FAIL shut_cool_sample: got %b/%0d want 1/120", bus.shutdown, bus.temp_out[7:0]); end
    step(0, 0, 0, 1);
    n_cmp++; if (bus.shutdown !== 1'b0) begin n_err++; $display("FAIL shut_release: got %b want 0", bus.shutdown); end
  endtask

  task automatic test_simultaneous();
    reset_dut();
    step(1, 3, 255, 0);
    step(1, 3, 255, 0);
    step(1, 3, 255, 1);
    n_cmp++; if (bus.shutdown !== 1'b1 || bus.shutdown_src !== 2'd3) begin n_err++; $display("FAIL simul_trip_wins: got %b/%0d want 1/3", bus.shutdown, bus.shutdown_src); end
    n_cmp++; if (bus.temp_out[31:24] !== 8'd0) begin n_err++; $display("FAIL simul_no_store: got %0d want 0", bus.temp_out[31:24]); end
    for (int i = 0; i < 3; i++) step(1, 1, 255, 0);
    n_cmp++; if (bus.shutdown !== 1'b1 || bus.shutdown_src !== 2'd3) begin n_err++; $display("FAIL simul_src_kept: got %b/%0d want 1/3", bus.shutdown, bus.shutdown_src); end
    step(1, 1, 120, 0);
    step(1, 3, 120, 0);
    step(0, 0, 0, 1);
    n_cmp++; if (bus.shutdown !== 1'b0) begin n_err++; $display("FAIL simul_release: got %b want 0", bus.shutdown); end
    step(1, 2, 250, 0); step(1, 1, 250, 0); step(1, 2, 250, 0); step(1, 1, 250, 0);
    step(1, 2, 250, 0);
    step(1, 1, 250, 0);
    n_cmp++; if (bus.shutdown !== 1'b1 || bus.shutdown_src !== 2'd2) begin n_err++; $display("FAIL simul_first_src: got %b/%0d want 1/2", bus.shutdown, bus.shutdown_src); end
  endtask

  task automatic test_fault();
    reset_dut();
    step(1, 0, 210, 0);
    step(1, 0, 210, 0);
    step(1, 0, 50, 0);
    n_cmp++; if (bus.fault !== 4'b0001 || bus.temp_upd !== 4'b0) begin n_err++; $display("FAIL fault_set: got %b/%b want 0001/0000", bus.fault, bus.temp_upd); end
    n_cmp++; if (bus.alarm[0] !== 1'b0) begin n_err++; $display("FAIL fault_no_alarm: got %b want 0", bus.alarm[0]); end
    step(1, 0, 210, 0);
    n_cmp++; if (bus.alarm[0] !== 1'b1 || bus.fault[0] !== 1'b1) begin n_err++; $display("FAIL fault_counter_kept: got alarm %b fault %b want 1/1", bus.alarm[0], bus.fault[0]); end
    step(1, 1, 99, 0);
    n_cmp++; if (bus.fault !== 4'b0011 || bus.temp_upd !== 4'b0) begin n_err++; $display("FAIL fault_edge: got %b/%b want 0011/0000", bus.fault, bus.temp_upd); end
  endtask

  task automatic test_ch_err();
    reset_dut();
    bus5.adc_valid = 1'b1; bus5.adc_ch = 3'd5; bus5.adc_data = 8'd150;
    @(posedge clk); #1;
    bus5.adc_valid = 1'b0;
    n_cmp++; if (bus5.ch_err !== 1'b1) begin n_err++; $display("FAIL cherr_pulse: got %b want 1", bus5.ch_err); end
    n_cmp++; if (bus5.temp_upd !== 5'b0 || bus5.temp_out !== 40'd0) begin n_err++; $display("FAIL cherr_no_store: got %b/%h want 0/0", bus5.temp_upd, bus5.temp_out); end
    @(posedge clk); #1;
    n_cmp++; if (bus5.ch_err !== 1'b0) begin n_err++; $display("FAIL cherr_one_cycle: got %b want 0", bus5.ch_err); end
    bus5.adc_valid = 1'b1; bus5.adc_ch = 3'd4; bus5.adc_data = 8'd150;
    @(posedge clk); #1;
    n_cmp++; if (bus5.ch_err !== 1'b0 || bus5.temp_upd !== 5'b10000 || bus5.temp_out[39:32] !== 8'd150) begin n_err++; $display("FAIL cherr_last_ch: got %b/%b/%0d want 0/10000/150", bus5.ch_err, bus5.temp_upd, bus5.temp_out[39:32]); end
    bus5.adc_ch = 3'd7; bus5.adc_data = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    bus5.adc_valid = 1'b0;
    n_cmp++; if (bus5.shutdown !== 1'b0 || bus5.fault !== 5'b0 || bus5.ch_err !== 1'b1) begin n_err++; $display("FAIL cherr_no_state: got shut %b fault %b err %b want 0/0/1", bus5.shutdown, bus5.fault, bus5.ch_err); end
  endtask

  task automatic test_random();
    logic [NCH*8-1:0] exp_t;
    logic [NCH-1:0]   exp_a, exp_f;
    reset_dut();
    for (int i = 0; i < 1200; i++) begin
      bit v, clr, hot_ph;
      int ch, d, r;
      v      = ($urandom_range(0, 9) < 8);
      ch     = $urandom_range(0, NCH - 1);
      r      = $urandom_range(0, 99);
      hot_ph = ((i / 150) % 2) == 0;
      if (hot_ph)
        d = (r < 45) ? $urandom_range(245, 255) : (r < 80) ? $urandom_range(190, 215) :
            (r < 93) ? $urandom_range(100, 244) : $urandom_range(0, 110);
      else
        d = (r < 8) ? $urandom_range(245, 255) : (r < 40) ? $urandom_range(190, 215) :
            (r < 96) ? $urandom_range(100, 189) : $urandom_range(0, 110);
      clr = !v && ($urandom_range(0, 3) == 0);
      step(v, ch, d, clr);
      for (int c = 0; c < NCH; c++) begin
        exp_t[c*8 +: 8] = 8'(m_temp[c]);
        exp_a[c] = m_alarm[c];
        exp_f[c] = m_fault[c];
      end
      n_cmp++; if (bus.temp_out !== exp_t) begin n_err++; $display("FAIL rand_temp cyc %0d: got %h want %h", i, bus.temp_out, exp_t); end
      n_cmp++; if (bus.temp_upd !== m_upd) begin n_err++; $display("FAIL rand_upd cyc %0d: got %b want %b", i, bus.temp_upd, m_upd); end
      n_cmp++; if (bus.alarm !== exp_a) begin n_err++; $display("FAIL rand_alarm cyc %0d: got %b want %b", i, bus.alarm, exp_a); end
      n_cmp++; if (bus.fault !== exp_f) begin n_err++; $display("FAIL rand_fault cyc %0d: got %b want %b", i, bus.fault, exp_f); end
      n_cmp++; if (bus.shutdown !== m_shut) begin n_err++; $display("FAIL rand_shut cyc %0d: got %b want %b", i, bus.shutdown, m_shut); end
      if (m_shut) begin
        n_cmp++; if (bus.shutdown_src !== 2'(m_src)) begin n_err++; $display("FAIL rand_src cyc %0d: got %0d want %0d", i, bus.shutdown_src, m_src); end
      end
      n_cmp++; if (bus.ch_err !== 1'b0) begin n_err++; $display("FAIL rand_cherr cyc %0d: got %b want 0", i, bus.ch_err); end
    end
  endtask

  initial begin
    bus.adc_valid = 1'b0; bus.adc_ch = '0; bus.adc_data = '0; bus.clr_shutdown = 1'b0;
    bus5.adc_valid = 1'b0; bus5.adc_ch = '0; bus5.adc_data = '0; bus5.clr_shutdown = 1'b0;
    model_reset();
    test_reset();
    test_store();
    test_alarm();
    test_shutdown();
    test_simultaneous();
    test_fault();
    test_ch_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
